// File: rtl/eth_write_packer.sv
// Packs 32-bit payload words into DATA_W-bit write bursts with a minimum pulse gap.
// Optional PACKER_BYTE_SWAP_EN byte-reverses each word before packing.
module eth_write_packer #(
  parameter int DATA_W     = 768,
  parameter int WORDS      = DATA_W / 32,
  parameter int ADDR_STEP  = 24,
  parameter int GAP_CYCLES = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              phy_init_done,
  input  logic              frame_start,
  input  logic [31:0]       base_addr,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              write_out,
  output logic [31:0]       w_address_out,
  output logic [DATA_W-1:0] w_data_out
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [CW-1:0]     count_q;
  logic [31:0]       addr_q;
  logic              full_q;
  logic [GW-1:0]     gap_q;
  logic [DATA_W-1:0] buf_q;
  logic              reload_pend_q;
  logic [31:0]       reload_addr_q;

  logic              accept;
  logic              issue;
  logic [31:0]       word_in;
  logic [CW-1:0]     slot;
  logic              last_word;
  logic [DATA_W-1:0] buf_wr;

  assign s_ready = phy_init_done & ~full_q;
  assign accept  = s_valid & s_ready;
  assign issue   = full_q & (gap_q == '0) & phy_init_done;

`ifdef PACKER_BYTE_SWAP_EN
  assign word_in = {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]};
`else
  assign word_in = s_data;
`endif

  // A word arriving with frame_start lands in slot 0 of a freshly cleared buffer.
  assign slot      = frame_start ? '0 : count_q;
  assign last_word = s_last | (slot == CW'(WORDS - 1));

  always_comb begin
    buf_wr = frame_start ? '0 : buf_q;
    for (int k = 0; k < WORDS; k++) begin
      if (slot == CW'(k)) begin
        buf_wr[32*k +: 32] = word_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      addr_q        <= '0;
      full_q        <= 1'b0;
      gap_q         <= '0;
      buf_q         <= '0;
      reload_pend_q <= 1'b0;
      reload_addr_q <= '0;
      write_out     <= 1'b0;
      w_address_out <= '0;
      w_data_out    <= '0;
    end else begin
      write_out <= 1'b0;
      if (gap_q != '0) begin
        gap_q <= gap_q - GW'(1);
      end

      if (issue) begin
        write_out     <= 1'b1;
        w_data_out    <= buf_q;
        w_address_out <= addr_q;
        full_q        <= 1'b0;
        buf_q         <= '0;
        gap_q         <= GW'(GAP_CYCLES - 1);
        reload_pend_q <= 1'b0;
        if (frame_start) begin
          addr_q <= base_addr;
        end else if (reload_pend_q) begin
          addr_q <= reload_addr_q;
        end else begin
          addr_q <= addr_q + 32'(ADDR_STEP);
        end
      end else if (full_q) begin
        // The held burst keeps its address; the new base applies once it issues.
        if (frame_start) begin
          reload_pend_q <= 1'b1;
          reload_addr_q <= base_addr;
        end
      end else begin
        if (frame_start) begin
          addr_q <= base_addr;
        end
        if (accept) begin
          buf_q <= buf_wr;
          if (last_word) begin
            full_q  <= 1'b1;
            count_q <= '0;
          end else begin
            count_q <= slot + CW'(1);
          end
        end else if (frame_start) begin
          buf_q   <= '0;
          count_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_write_packer.sv
// Randomized bench for eth_write_packer against a frame-level burst model.
module tb_eth_write_packer;

  localparam int DATA_W = 768;
  localparam int WORDS  = 24;
  localparam int STEP   = 24;
  localparam int GAP    = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              phy_init_done = 1'b0;
  logic              frame_start = 1'b0;
  logic [31:0]       base_addr = '0;
  logic              s_valid = 1'b0;
  logic [31:0]       s_data = '0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic              write_out;
  logic [31:0]       w_address_out;
  logic [DATA_W-1:0] w_data_out;

  eth_write_packer dut (
    .clk(clk), .reset(reset), .phy_init_done(phy_init_done),
    .frame_start(frame_start), .base_addr(base_addr),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .write_out(write_out), .w_address_out(w_address_out), .w_data_out(w_data_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0]       a;
    logic [DATA_W-1:0] d;
  } burst_t;

  // Model: bursts take address frame_base + STEP * (burst index within frame).
  burst_t            exp_q[$];
  int                exp_t;
  logic [31:0]       cur_w[$];
  logic [31:0]       frame_base = '0;
  int                burst_idx = 0;
  int                last_pulse = -1000;
  int                cyc = 0;
  bit                mon_en = 1'b0;
  int                pulse_count = 0;
  logic [31:0]       last_addr;
  logic [DATA_W-1:0] last_data;

  function automatic logic [31:0] sw(input logic [31:0] d);
`ifdef PACKER_BYTE_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  always @(negedge clk) begin
    burst_t b;
    cyc++;
    if (mon_en) begin
      if (write_out) begin
        pulse_count++;
        last_addr = w_address_out;
        last_data = w_data_out;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: got pulse addr %h at cycle %0d, required no pulse", w_address_out, cyc);
        end else begin
          b = exp_q.pop_front();
          if (w_address_out !== b.a || w_data_out !== b.d || cyc != exp_t) begin
            n_err++;
            $display("FAIL burst: got addr %h cyc %0d data %h, required addr %h cyc %0d data %h",
                     w_address_out, cyc, w_data_out, b.a, exp_t, b.d);
          end
        end
        n_cmp++;
        if (cyc - last_pulse < GAP) begin
          n_err++;
          $display("FAIL gap: got spacing %0d, required >= %0d", cyc - last_pulse, GAP);
        end
        last_pulse = cyc;
      end else if (exp_q.size() != 0 && cyc >= exp_t) begin
        n_cmp++;
        n_err++;
        $display("FAIL late_pulse: got no pulse at cycle %0d, required pulse addr %h", cyc, exp_q[0].a);
        exp_t = cyc + 100000;
      end

      n_cmp++;
      if (s_ready !== (phy_init_done && exp_q.size() == 0)) begin
        n_err++;
        $display("FAIL s_ready: got %b, required %b at cycle %0d", s_ready,
                 (phy_init_done && exp_q.size() == 0), cyc);
      end

      if (!phy_init_done && exp_q.size() != 0 && exp_t < cyc + 2) exp_t = cyc + 2;

      if (reset) begin
        exp_q.delete();
        cur_w.delete();
        frame_base = '0;
        burst_idx  = 0;
        last_pulse = -1000;
      end else begin
        if (frame_start) begin
          cur_w.delete();
          frame_base = base_addr;
          burst_idx  = 0;
        end
        if (s_valid && phy_init_done && exp_q.size() == 0) begin
          cur_w.push_back(sw(s_data));
          if (s_last || cur_w.size() == WORDS) begin
            b.d = '0;
            foreach (cur_w[i]) b.d[32*i +: 32] = cur_w[i];
            b.a = frame_base + 32'(STEP * burst_idx);
            exp_q.push_back(b);
            exp_t = (cyc + 2 > last_pulse + GAP) ? cyc + 2 : last_pulse + GAP;
            burst_idx++;
            cur_w.delete();
          end
        end
      end
    end
  end

  task automatic send(input int n, input bit last_end, input int bubble, input bit fs,
                      input logic [31:0] base, input bit rnd, input logic [31:0] first);
    bit acc;
    int tmo;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(99) < bubble) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = rnd ? $urandom : first + 32'(i);
      s_last  = last_end && (i == n - 1);
      if (fs && i == 0) begin
        frame_start = 1'b1;
        base_addr   = base;
      end
      tmo = 0;
      do begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk); #1;
        frame_start = 1'b0;
        tmo++;
      end while (!acc && tmo < 500);
      if (!acc) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: got no accept of word %0d, required accept within 500 cycles", i);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int tmo = 0;
    while (exp_q.size() != 0 && tmo < 300) begin
      @(posedge clk); #1;
      tmo++;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d bursts outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic check_int(input string name, input longint got, input longint req);
    n_cmp++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (write_out !== 1'b0 || w_address_out !== 32'h0 || w_data_out !== '0 || s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got wo %b addr %h rdy %b, required all 0", write_out, w_address_out, s_ready);
    end
    phy_init_done = 1'b1;
    #1;
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b, required 1", s_ready);
    end
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  task automatic test_full_burst();
    int p0 = pulse_count;
    logic [DATA_W-1:0] e = '0;
    send(WORDS, 1'b0, 0, 1'b1, 32'h100, 1'b0, 32'h0);
    drain();
    for (int k = 0; k < WORDS; k++) e[32*k +: 32] = sw(32'(k));
    check_int("full_count", pulse_count - p0, 1);
    check_int("full_addr", last_addr, 32'h100);
    n_cmp++;
    if (last_data !== e) begin
      n_err++;
      $display("FAIL full_data: got %h, required %h", last_data, e);
    end
  endtask

  task automatic test_partial_last();
    int p0 = pulse_count;
    logic [DATA_W-1:0] e = '0;
    send(30, 1'b1, 0, 1'b1, 32'h100, 1'b0, 32'h0);
    drain();
    for (int k = 0; k < 6; k++) e[32*k +: 32] = sw(32'(24 + k));
    check_int("partial_count", pulse_count - p0, 2);
    check_int("partial_addr", last_addr, 32'h118);
    n_cmp++;
    if (last_data !== e) begin
      n_err++;
      $display("FAIL partial_data: got %h, required %h", last_data, e);
    end
  endtask

  task automatic test_continuous();
    int p0 = pulse_count;
    send(72, 1'b0, 0, 1'b1, 32'h200, 1'b1, 32'h0);
    drain();
    check_int("cont_count", pulse_count - p0, 3);
    check_int("cont_addr", last_addr, 32'h230);
  endtask

  task automatic test_frame_restart();
    int p0 = pulse_count;
    send(10, 1'b0, 20, 1'b1, 32'h300, 1'b1, 32'h0);
    send(WORDS, 1'b0, 20, 1'b1, 32'h400, 1'b1, 32'h0);
    drain();
    check_int("restart_count", pulse_count - p0, 1);
    check_int("restart_addr", last_addr, 32'h400);
  endtask

  task automatic test_mid_reset();
    int p0 = pulse_count;
    logic [DATA_W-1:0] e = '0;
    send(12, 1'b0, 0, 1'b1, 32'h500, 1'b0, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("reset_no_pulse", pulse_count - p0, 0);
    send(WORDS, 1'b0, 0, 1'b0, 32'h0, 1'b0, 32'h1000);
    drain();
    for (int k = 0; k < WORDS; k++) e[32*k +: 32] = sw(32'h1000 + 32'(k));
    check_int("reset_count", pulse_count - p0, 1);
    check_int("reset_addr", last_addr, 32'h0);
    n_cmp++;
    if (last_data !== e) begin
      n_err++;
      $display("FAIL reset_data: got %h, required %h", last_data, e);
    end
  endtask

  task automatic test_wrap();
    send(2 * WORDS, 1'b0, 10, 1'b1, 32'hFFFF_FFF0, 1'b1, 32'h0);
    drain();
    check_int("wrap_addr", last_addr, 32'h8);
  endtask

  task automatic test_byte_swap();
    logic [31:0] req;
`ifdef PACKER_BYTE_SWAP_EN
    req = 32'h4433_2211;
`else
    req = 32'h1122_3344;
`endif
    send(1, 1'b1, 0, 1'b1, 32'h0, 1'b0, 32'h1122_3344);
    drain();
    check_int("swap_word0", last_data[31:0], req);
    check_int("swap_word1", last_data[63:32], 0);
  endtask

  task automatic test_random();
    bit done = 1'b0;
    fork
      begin
        for (int it = 0; it < 20; it++) begin
          send($urandom_range(1, 60), 1'($urandom_range(1)), 30, 1'($urandom_range(1)),
               $urandom, 1'b1, 32'h0);
          repeat ($urandom_range(0, 8)) @(posedge clk);
          #1;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          phy_init_done = ($urandom_range(7) != 0);
        end
        phy_init_done = 1'b1;
      end
    join
    drain();
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_partial_last();
    test_continuous();
    test_frame_restart();
    test_mid_reset();
    test_wrap();
    test_byte_swap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
